// File: rtl/cdb_arbiter_if.sv
// Purpose: requester and CDB broadcast bundle between the FU result slots and the CDB arbiter.
// Latency: none; this is wiring only.
// Backpressure: a requester holds req_* stable until its grant bit is seen high.
interface cdb_arbiter_if #(
    parameter int NUM_REQ = 8,
    parameter int N_CDB   = 2,
    parameter int TAG_W   = 6,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*TAG_W-1:0]  req_tag;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        grant;
    logic [N_CDB-1:0]          cdb_valid;
    logic [N_CDB*TAG_W-1:0]    cdb_tag;
    logic [N_CDB*DATA_W-1:0]   cdb_data;

    // FU side: presents results, observes grants and the broadcast
    modport master (
        output req_valid, req_tag, req_data,
        input  grant, cdb_valid, cdb_tag, cdb_data
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_tag, req_data,
        output grant, cdb_valid, cdb_tag, cdb_data
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Purpose: picks up to N_CDB FU results per cycle (starved first, then round-robin) for the CDB; optional CDB_ARB_PERF_EN adds grant/conflict counters.
// Latency: grant is combinational; granted results appear on the registered CDB one cycle later.
// Backpressure: an ungranted requester simply stalls with its result held; flush suppresses all grants.
module cdb_arbiter #(
    parameter int NUM_REQ      = 8,
    parameter int N_CDB        = 2,
    parameter int TAG_W        = 6,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          flush_i,
    cdb_arbiter_if.slave  bus
`ifdef CDB_ARB_PERF_EN
    ,
    output logic [31:0]   perf_grant_cnt_o,
    output logic [31:0]   perf_conflict_cnt_o
`endif
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]        rr_q, rr_d;
    logic [3:0]              wait_q [NUM_REQ];
    logic [3:0]              wait_d [NUM_REQ];
    logic [NUM_REQ-1:0]      starved_c;
    logic [NUM_REQ-1:0]      grant_c;
    logic [N_CDB-1:0]        lane_vld_c;
    logic [PTR_W-1:0]        lane_idx_c [N_CDB];
    logic                    p2_any_c;
    logic [PTR_W-1:0]        p2_last_c;

    logic [N_CDB-1:0]        cdb_valid_q, cdb_valid_d;
    logic [N_CDB*TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [N_CDB*DATA_W-1:0] cdb_data_q, cdb_data_d;

    // A requester is starved once its consecutive-denial count reaches the limit
    always_comb begin
        starved_c = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            starved_c[i] = (wait_q[i] >= 4'(STARVE_LIMIT));
        end
    end

    // Fill lanes in order: starved requesters by lowest index, then a circular scan from rr_q
    always_comb begin : grant_sel
        logic                found;
        logic [NUM_REQ-1:0]  taken;
        taken      = '0;
        found      = 1'b0;
        lane_vld_c = '0;
        p2_any_c   = 1'b0;
        p2_last_c  = '0;
        for (int l = 0; l < N_CDB; l++) begin
            lane_idx_c[l] = '0;
        end
        if (reset_i && !flush_i) begin
            for (int l = 0; l < N_CDB; l++) begin
                found = 1'b0;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!found && bus.req_valid[i] && starved_c[i] && !taken[i]) begin
                        found         = 1'b1;
                        taken[i]      = 1'b1;
                        lane_vld_c[l] = 1'b1;
                        lane_idx_c[l] = PTR_W'(i);
                    end
                end
                // circular scan split into [rr_q, NUM_REQ) followed by [0, rr_q)
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!found && (i >= int'(rr_q)) && bus.req_valid[i] && !taken[i]) begin
                        found         = 1'b1;
                        taken[i]      = 1'b1;
                        lane_vld_c[l] = 1'b1;
                        lane_idx_c[l] = PTR_W'(i);
                        p2_any_c      = 1'b1;
                        p2_last_c     = PTR_W'(i);
                    end
                end
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!found && (i < int'(rr_q)) && bus.req_valid[i] && !taken[i]) begin
                        found         = 1'b1;
                        taken[i]      = 1'b1;
                        lane_vld_c[l] = 1'b1;
                        lane_idx_c[l] = PTR_W'(i);
                        p2_any_c      = 1'b1;
                        p2_last_c     = PTR_W'(i);
                    end
                end
            end
        end
        grant_c = taken;
    end

    // Steer each granted requester's tag/data onto its lane; empty lanes carry zeros
    always_comb begin
        cdb_valid_d = lane_vld_c;
        cdb_tag_d   = '0;
        cdb_data_d  = '0;
        for (int l = 0; l < N_CDB; l++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (lane_vld_c[l] && (lane_idx_c[l] == PTR_W'(i))) begin
                    cdb_tag_d[l*TAG_W +: TAG_W]    = bus.req_tag[i*TAG_W +: TAG_W];
                    cdb_data_d[l*DATA_W +: DATA_W] = bus.req_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Denial counters saturate at the limit; a grant, an idle slot or a flush clears them
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            wait_d[i] = '0;
            if (!flush_i && bus.req_valid[i] && !grant_c[i]) begin
                wait_d[i] = starved_c[i] ? 4'(STARVE_LIMIT) : (wait_q[i] + 4'd1);
            end
        end
    end

    // Round-robin pointer moves just past the last scan-granted requester
    always_comb begin
        rr_d = rr_q;
        if (p2_any_c) begin
            rr_d = (p2_last_c == PTR_W'(NUM_REQ - 1)) ? '0 : (p2_last_c + 1'b1);
        end
    end

    // State and registered CDB; reset clears the broadcast immediately
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            rr_q        <= '0;
            cdb_valid_q <= '0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_q[i] <= '0;
            end
        end else begin
            rr_q        <= rr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_q[i] <= wait_d[i];
            end
        end
    end

    assign bus.grant     = grant_c;
    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_data  = cdb_data_q;

`ifdef CDB_ARB_PERF_EN
    logic [31:0] perf_grant_q, perf_conflict_q;

    // Free-running wrap-around counters of grants and oversubscribed cycles
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            perf_grant_q    <= '0;
            perf_conflict_q <= '0;
        end else begin
            perf_grant_q <= perf_grant_q + 32'($countones(grant_c));
            if (!flush_i && ($countones(bus.req_valid) > N_CDB)) begin
                perf_conflict_q <= perf_conflict_q + 32'd1;
            end
        end
    end

    assign perf_grant_cnt_o    = perf_grant_q;
    assign perf_conflict_cnt_o = perf_conflict_q;
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
    localparam int NUM_REQ = 8;
    localparam int N_CDB   = 2;
    localparam int TAG_W   = 6;
    localparam int DATA_W  = 32;

    typedef struct {
        logic       flush;
        logic [7:0] vld;
        logic [7:0] grant;
        int         l0;
        int         l1;
    } vec_t;

    logic clock = 1'b0;
    logic reset_n;
    logic flush;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*TAG_W-1:0]  req_tag;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [5:0]  tag_tab  [NUM_REQ];
    logic [31:0] data_tab [NUM_REQ];
    int errors = 0;
    int checks = 0;
    vec_t va [9];
    vec_t vs [7];

    always #5 clock = ~clock;

    cdb_arbiter_if #(.NUM_REQ(NUM_REQ), .N_CDB(N_CDB), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus_a ();
    cdb_arbiter_if #(.NUM_REQ(NUM_REQ), .N_CDB(N_CDB), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus_s ();

    assign bus_a.req_valid = req_valid;
    assign bus_a.req_tag   = req_tag;
    assign bus_a.req_data  = req_data;
    assign bus_s.req_valid = req_valid;
    assign bus_s.req_tag   = req_tag;
    assign bus_s.req_data  = req_data;

`ifdef CDB_ARB_PERF_EN
    logic [31:0] pg_a, pc_a, pg_s, pc_s;
`endif

    cdb_arbiter #(.NUM_REQ(NUM_REQ), .N_CDB(N_CDB), .TAG_W(TAG_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
        .clock_i(clock), .reset_i(reset_n), .flush_i(flush), .bus(bus_a)
`ifdef CDB_ARB_PERF_EN
        , .perf_grant_cnt_o(pg_a), .perf_conflict_cnt_o(pc_a)
`endif
    );

    // short starvation limit so the override path is reachable under round-robin
    cdb_arbiter #(.NUM_REQ(NUM_REQ), .N_CDB(N_CDB), .TAG_W(TAG_W), .DATA_W(DATA_W), .STARVE_LIMIT(2)) dut_s (
        .clock_i(clock), .reset_i(reset_n), .flush_i(flush), .bus(bus_s)
`ifdef CDB_ARB_PERF_EN
        , .perf_grant_cnt_o(pg_s), .perf_conflict_cnt_o(pc_s)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one vector at the current negedge, check grant, then the CDB after the edge
    task automatic run_vec(input vec_t v, input int which, input int row);
        logic [1:0]  ev;
        logic [11:0] et;
        logic [63:0] ed;
        logic [7:0]  g;
        logic [1:0]  cv;
        logic [11:0] ct;
        logic [63:0] cd;
        ev = 2'b00; et = '0; ed = '0;
        if (v.l0 >= 0) begin ev[0] = 1'b1; et[5:0]  = tag_tab[v.l0]; ed[31:0]  = data_tab[v.l0]; end
        if (v.l1 >= 0) begin ev[1] = 1'b1; et[11:6] = tag_tab[v.l1]; ed[63:32] = data_tab[v.l1]; end
        flush     = v.flush;
        req_valid = v.vld;
        #1;
        g = (which == 0) ? bus_a.grant : bus_s.grant;
        check($sformatf("grant[%0d.%0d]", which, row), 64'(g), 64'(v.grant));
        @(posedge clock);
        #1;
        cv = (which == 0) ? bus_a.cdb_valid : bus_s.cdb_valid;
        ct = (which == 0) ? bus_a.cdb_tag   : bus_s.cdb_tag;
        cd = (which == 0) ? bus_a.cdb_data  : bus_s.cdb_data;
        check($sformatf("cdb_valid[%0d.%0d]", which, row), 64'(cv), 64'(ev));
        check($sformatf("cdb_tag[%0d.%0d]", which, row), 64'(ct), 64'(et));
        check($sformatf("cdb_data[%0d.%0d]", which, row), cd, ed);
        @(negedge clock);
    endtask

    initial begin
        tag_tab = '{6'd3, 6'd5, 6'd9, 6'd12, 6'd17, 6'd22, 6'd40, 6'd63};
        for (int i = 0; i < NUM_REQ; i++) begin
            data_tab[i] = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
            req_tag[i*TAG_W +: TAG_W]    = tag_tab[i];
            req_data[i*DATA_W +: DATA_W] = data_tab[i];
        end

        // main instance, limit 4: round-robin sweep, pointer checks, flush
        va[0] = '{1'b0, 8'hFF, 8'h03, 0, 1};
        va[1] = '{1'b0, 8'hFF, 8'h0C, 2, 3};
        va[2] = '{1'b0, 8'hFF, 8'h30, 4, 5};
        va[3] = '{1'b0, 8'hFF, 8'hC0, 6, 7};
        va[4] = '{1'b0, 8'h00, 8'h00, -1, -1};
        va[5] = '{1'b0, 8'h05, 8'h05, 0, 2};
        va[6] = '{1'b0, 8'hFF, 8'h18, 3, 4};
        va[7] = '{1'b1, 8'hFF, 8'h00, -1, -1};
        va[8] = '{1'b0, 8'hFF, 8'h60, 5, 6};
        // limit-2 instance from reset: starvation override, lowest index wins, flush clears counters
        vs[0] = '{1'b0, 8'hFF, 8'h03, 0, 1};
        vs[1] = '{1'b0, 8'hFF, 8'h0C, 2, 3};
        vs[2] = '{1'b0, 8'hFF, 8'h30, 4, 5};
        vs[3] = '{1'b0, 8'hFF, 8'h03, 0, 1};
        vs[4] = '{1'b0, 8'hA3, 8'hA0, 7, 5};
        vs[5] = '{1'b1, 8'hFF, 8'h00, -1, -1};
        vs[6] = '{1'b0, 8'hFF, 8'hC0, 6, 7};

        reset_n   = 1'b0;
        flush     = 1'b0;
        req_valid = 8'hFF;
        #1;
        check("reset_grant", 64'(bus_a.grant), 64'h0);
        check("reset_cdb_valid", 64'(bus_a.cdb_valid), 64'h0);
        check("reset_cdb_tag", 64'(bus_a.cdb_tag), 64'h0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int r = 0; r < 9; r++) run_vec(va[r], 0, r);

        // CDB currently carries requesters 5 and 6; assert reset mid-cycle
        check("pre_reset_valid", 64'(bus_a.cdb_valid), 64'h3);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(bus_a.cdb_valid), 64'h0);
        check("async_rst_tag", 64'(bus_a.cdb_tag), 64'h0);
        check("async_rst_data", 64'(bus_a.cdb_data), 64'h0);
        check("async_rst_grant", 64'(bus_a.grant), 64'h0);
        @(posedge clock);
        #1;
        check("rst_hold_valid", 64'(bus_a.cdb_valid), 64'h0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("post_rst_grant", 64'(bus_a.grant), 64'h03);

        for (int r = 0; r < 7; r++) run_vec(vs[r], 1, r);

`ifdef CDB_ARB_PERF_EN
        reset_n = 1'b0;
        #1;
        check("perf_rst_grant", 64'(pg_a), 64'h0);
        @(negedge clock);
        reset_n   = 1'b1;
        flush     = 1'b0;
        req_valid = 8'h1F;
        repeat (3) @(posedge clock);
        #1;
        check("perf_grant_cnt", 64'(pg_a), 64'd6);
        check("perf_conflict_cnt", 64'(pc_a), 64'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
